// File: rtl/vend_pkg.sv
// Shared types, constants and helpers for the vend_ctrl_n vending controller.
package vend_pkg;

    localparam int NUM_COIN    = 3;
    localparam int MAX_TABLE_W = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_PAYOUT  = 3'd3
    } vend_state_t;

    // Returns entry idx of a packed table whose entries are width bits wide.
    function automatic logic [31:0] price_of(input logic [MAX_TABLE_W-1:0] tbl_bits,
                                             input int idx,
                                             input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return 32'(tbl_bits >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/vend_ctrl_n_if.sv
// Coin/selection inputs and status outputs of the vending controller.
interface vend_ctrl_n_if #(
    parameter int GOODS_W = 3,
    parameter int PRICE_W = 8
);
    import vend_pkg::*;

    logic [NUM_COIN-1:0] coin_in;
    logic [GOODS_W-1:0]  goods_sel;
    logic                confirm;
    logic                cancel;
    logic [PRICE_W-1:0]  credit;
    logic                dispense;
    logic [GOODS_W-1:0]  dispense_id;
    logic [NUM_COIN-1:0] coin_out;
    logic [NUM_COIN-1:0] coin_rej;
    logic                err_funds;
    logic [2:0]          state_o;

    modport master (
        output coin_in, goods_sel, confirm, cancel,
        input  credit, dispense, dispense_id, coin_out, coin_rej, err_funds, state_o
    );

    modport slave (
        input  coin_in, goods_sel, confirm, cancel,
        output credit, dispense, dispense_id, coin_out, coin_rej, err_funds, state_o
    );

endinterface

// File: rtl/vend_payout.sv
// Greedy change engine: pays an amount back one coin at a time, largest coin
// first, with a fixed idle gap between pulses. A residual smaller than the
// smallest coin is forfeited.
module vend_payout
    import vend_pkg::*;
#(
    parameter int PRICE_W    = 8,
    parameter int COIN_V0    = 1,
    parameter int COIN_V1    = 5,
    parameter int COIN_V2    = 10,
    parameter int PAYOUT_GAP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PRICE_W-1:0]  amount,
    output logic [NUM_COIN-1:0] coin_out,
    output logic [PRICE_W-1:0]  remaining,
    output logic                done
);

    localparam int GAP_W = (PAYOUT_GAP > 2) ? $clog2(PAYOUT_GAP) : 1;

    logic               busy;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PRICE_W-1:0] pick_val;
    logic               decide;

    // Choose the largest coin that still fits, or signal completion.
    always_comb begin
        coin_out = '0;
        pick_val = '0;
        done     = 1'b0;
        decide   = busy && (gap_cnt == '0);
        if (decide) begin
            if (remaining >= PRICE_W'(COIN_V2)) begin
                coin_out = 3'b100;
                pick_val = PRICE_W'(COIN_V2);
            end else if (remaining >= PRICE_W'(COIN_V1)) begin
                coin_out = 3'b010;
                pick_val = PRICE_W'(COIN_V1);
            end else if (remaining >= PRICE_W'(COIN_V0)) begin
                coin_out = 3'b001;
                pick_val = PRICE_W'(COIN_V0);
            end else begin
                done = 1'b1;
            end
        end
    end

    // Track the amount still owed and the spacing between coin pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            remaining <= '0;
            gap_cnt   <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            remaining <= amount;
            gap_cnt   <= '0;
        end else if (decide) begin
            if (done) begin
                busy      <= 1'b0;
                remaining <= '0;
            end else begin
                remaining <= remaining - pick_val;
                gap_cnt   <= GAP_W'(PAYOUT_GAP - 1);
            end
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/vend_ctrl_n.sv
// Vending transaction controller: collects credit from coin pulses, checks
// purchases against a price table, dispenses, and returns change or refunds
// through the greedy payout engine.
module vend_ctrl_n
    import vend_pkg::*;
#(
    parameter int GOODS_W = 3,
    parameter int PRICE_W = 8,
    parameter logic [PRICE_W*(2**GOODS_W)-1:0] PRICES =
        {8'd50, 8'd40, 8'd30, 8'd25, 8'd20, 8'd12, 8'd8, 8'd0},
    parameter int COIN_V0 = 1,
    parameter int COIN_V1 = 5,
    parameter int COIN_V2 = 10,
    parameter int unsigned TIMEOUT_CYC = 1500000000,
    parameter int PAYOUT_GAP = 4
) (
    input logic          clk,
    input logic          rst,
    vend_ctrl_n_if.slave bus
);

    localparam int SUM_W = PRICE_W + 2;

    vend_state_t         state_q, state_d;
    logic [PRICE_W-1:0]  credit_q, credit_d;
    logic [31:0]         timer_q, timer_d;
    logic [GOODS_W-1:0]  id_q, id_d;
    logic                err_q, err_d;
    logic [NUM_COIN-1:0] rej_q, rej_d;

    logic [SUM_W-1:0]    coin_sum;
    logic                overflow;
    logic                coin_state;
    logic                accept;
    logic [PRICE_W-1:0]  acc_sum;
    logic [PRICE_W-1:0]  credit_plus;
    logic [PRICE_W-1:0]  price_sel;

    logic                pay_start;
    logic [PRICE_W-1:0]  pay_amount;
    logic [NUM_COIN-1:0] pay_coin;
    logic [PRICE_W-1:0]  pay_remaining;
    logic                pay_done;

    assign price_sel = PRICE_W'(price_of(MAX_TABLE_W'(PRICES), int'(bus.goods_sel), PRICE_W));

    // Value of this cycle's coins and whether adding them would overflow credit.
    always_comb begin
        coin_sum = '0;
        if (bus.coin_in[0]) coin_sum = coin_sum + SUM_W'(COIN_V0);
        if (bus.coin_in[1]) coin_sum = coin_sum + SUM_W'(COIN_V1);
        if (bus.coin_in[2]) coin_sum = coin_sum + SUM_W'(COIN_V2);
        overflow    = ({2'b00, credit_q} + coin_sum) > {2'b00, {PRICE_W{1'b1}}};
        coin_state  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
        accept      = coin_state && !overflow && (bus.coin_in != '0);
        acc_sum     = accept ? coin_sum[PRICE_W-1:0] : '0;
        credit_plus = credit_q + acc_sum;
    end

    // Next-state logic: coin acceptance, purchase decision, timeout, payout hand-off.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        timer_d    = timer_q;
        id_d       = id_q;
        err_d      = 1'b0;
        rej_d      = (coin_state && !overflow) ? '0 : bus.coin_in;
        pay_start  = 1'b0;
        pay_amount = credit_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept) begin
                    credit_d = credit_plus;
                    state_d  = ST_COLLECT;
                end
                if (bus.confirm) err_d = 1'b1;
            end
            ST_COLLECT: begin
                if (bus.cancel) begin
                    timer_d    = '0;
                    pay_start  = 1'b1;
                    pay_amount = credit_plus;
                    credit_d   = '0;
                    state_d    = ST_PAYOUT;
                end else if (bus.confirm) begin
                    timer_d = '0;
                    if ((price_sel != '0) && (credit_q >= price_sel)) begin
                        id_d     = bus.goods_sel;
                        credit_d = credit_q - price_sel + acc_sum;
                        state_d  = ST_VEND;
                    end else begin
                        err_d    = 1'b1;
                        credit_d = credit_plus;
                    end
                end else if (accept) begin
                    timer_d  = '0;
                    credit_d = credit_plus;
                end else if (timer_q == 32'(TIMEOUT_CYC - 1)) begin
                    timer_d    = '0;
                    pay_start  = 1'b1;
                    pay_amount = credit_q;
                    credit_d   = '0;
                    state_d    = ST_PAYOUT;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_VEND: begin
                if (credit_q != '0) begin
                    pay_start  = 1'b1;
                    pay_amount = credit_q;
                    credit_d   = '0;
                    state_d    = ST_PAYOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYOUT: begin
                if (pay_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state register; reset abandons any transaction in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            id_q     <= id_d;
            err_q    <= err_d;
            rej_q    <= rej_d;
        end
    end

    vend_payout #(
        .PRICE_W   (PRICE_W),
        .COIN_V0   (COIN_V0),
        .COIN_V1   (COIN_V1),
        .COIN_V2   (COIN_V2),
        .PAYOUT_GAP(PAYOUT_GAP)
    ) u_payout (
        .clk      (clk),
        .rst      (rst),
        .start    (pay_start),
        .amount   (pay_amount),
        .coin_out (pay_coin),
        .remaining(pay_remaining),
        .done     (pay_done)
    );

    assign bus.credit      = (state_q == ST_PAYOUT) ? pay_remaining : credit_q;
    assign bus.dispense    = (state_q == ST_VEND);
    assign bus.dispense_id = id_q;
    assign bus.coin_out    = (state_q == ST_PAYOUT) ? pay_coin : '0;
    assign bus.coin_rej    = rej_q;
    assign bus.err_funds   = err_q;
    assign bus.state_o     = state_q;

endmodule
